imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  one-cycle pulse; begins a load session from IDLE or DONE.
REQ-004 s_valid  in  1  byte-stream valid.
REQ-005 s_ready  out  1  byte-stream ready; a byte transfers on a rising edge where s_valid && s_ready.
REQ-006 s_data  in  8  stream byte.
REQ-007 s_last  in  1  marks the final program byte; sampled only with a transferred byte.
REQ-008 we  out  1  instruction-memory write enable, one cycle per word.
REQ-009 wa  out  6  instruction-memory word address, same 6-bit word address space the imem read port decodes.
REQ-010 wd  out  32  instruction-memory write data.
REQ-011 busy  out  1  high while loading; holds the CPU in reset.
REQ-012 done  out  1  high in DONE.
REQ-013 words  out  7  count of words written this session, 0..64.
REQ-014 err  out  1  session error flag, valid in DONE.

Function
REQ-015 States: IDLE, LOAD, CHECK (only with macro), DONE.
REQ-016 IDLE/DONE: start=1 -> LOAD next cycle; words, byte index, assembly register and err clear.
REQ-017 start in LOAD or CHECK is ignored.
REQ-018 s_ready=1 exactly in LOAD and CHECK; 0 otherwise, including the cycle of entry into DONE.
REQ-019 Bytes pack little-endian: byte index 0 -> wd[7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-020 Transfer of byte index 3 -> next cycle we=1 for one cycle, wa=words[5:0], wd=assembled word; words increments in that same cycle.
REQ-021 s_last on byte index k<3 -> unfilled upper bytes zero; word written with the REQ-020 timing.
REQ-022 Byte index wraps 3 -> 0 after each word; s_ready stays 1, back-to-back bytes every cycle, no bubbles.
REQ-023 Word write carrying s_last -> CHECK (macro on) or DONE (macro off) the cycle after we.
REQ-024 64th word written without s_last -> DONE, err=1; no further bytes accepted.
REQ-025 s_last on the 64th word -> normal completion, err=0.
REQ-026 busy=1 in LOAD and CHECK; done=1 in DONE; both 0 in IDLE.
REQ-027 we never asserts outside the REQ-020/021 cycle; wa and wd hold their last value while we=0.

Reset
REQ-028 reset=1 -> state IDLE; s_ready, we, busy, done, err=0; wa=0, wd=0, words=0, byte index 0.
REQ-029 Reset mid-session aborts it immediately; a pending write not yet issued is dropped; memory contents already written are not erased.
REQ-030 reset takes priority over start and over any byte transfer in the same cycle.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN defined: running 32-bit sum (mod 2^32) of every written wd; CHECK accepts 4 little-endian bytes as the expected sum (s_last ignored); after the 4th byte -> DONE next cycle, err=1 iff mismatch.
REQ-032 Macro not defined: no CHECK state, no sum register; err reflects only REQ-024.

Verification
REQ-033 start; bytes 13 00 00 20 (s_last on 4th) -> one we, wa=0, wd=0x20000013; done=1 and words=1 the cycle after we; err=0.
REQ-034 start; 9 bytes every cycle, s_last on 9th = 0xAB -> writes wa=0,1,2; wa=2 wd=0x000000AB; words=3.
REQ-035 start; 256 bytes, no s_last -> 64 writes wa=0..63, DONE, err=1, s_ready=0 afterwards.
REQ-036 reset asserted after 6 bytes -> all outputs at reset values next cycle; a new start loads again from wa=0.
REQ-037 Macro on: words 0x00000001, 0x00000002, then 03 00 00 00 -> err=0; the same load with checksum 04 00 00 00 -> err=1.
REQ-038 s_valid toggling 1/0 each cycle and start pulsed during LOAD -> identical writes to the gap-free case; start has no effect.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake carrying program bytes into the loader.
interface imem_loader_if;
  localparam int unsigned DATA_W = 8;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit instruction-memory
// words, one write per word, and reports session status.
// Build macro IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit checksum check.
module imem_loader (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        strm,
  output logic                we,
  output logic [5:0]          wa,
  output logic [31:0]         wd,
  output logic                busy,
  output logic                done,
  output logic [6:0]          words,
  output logic                err
);
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CNT_W     = 7;
  localparam int unsigned MAX_WORDS = 64;

  // S_FLUSH is the write cycle of the final word: still busy, stream closed.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd3;
`endif

  logic [2:0]        state, state_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [WORD_W-1:0] assy, assy_n;
  logic              ready, ready_n;
  logic              we_n;
  logic [ADDR_W-1:0] wa_n;
  logic [WORD_W-1:0] wd_n;
  logic              busy_n, done_n, err_n;
  logic [CNT_W-1:0]  words_n;
  logic              xfer_c;
  logic [WORD_W-1:0] merged_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum, sum_n;
  logic              to_check, to_check_n;
`endif

  assign strm.s_ready = ready;
  assign xfer_c       = strm.s_valid && ready;
  // Current byte dropped into its lane on top of the partially assembled word.
  assign merged_c     = assy | (WORD_W'(strm.s_data) << {byte_idx, 3'b000});

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    assy_n     = assy;
    words_n    = words;
    we_n       = 1'b0;
    wa_n       = wa;
    wd_n       = wd;
    err_n      = err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_n      = sum;
    to_check_n = to_check;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n    = S_LOAD;
          byte_idx_n = 2'd0;
          assy_n     = '0;
          words_n    = '0;
          err_n      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_n      = '0;
          to_check_n = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (xfer_c) begin
          if (byte_idx == 2'd3 || strm.s_last) begin
            we_n       = 1'b1;
            wa_n       = words[ADDR_W-1:0];
            wd_n       = merged_c;
            words_n    = words + CNT_W'(1);
            byte_idx_n = 2'd0;
            assy_n     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_n      = sum + merged_c;
`endif
            if (strm.s_last) begin
              state_n    = S_FLUSH;
`ifdef IMEM_LOADER_CHECKSUM_EN
              to_check_n = 1'b1;
`endif
            end else if (words == CNT_W'(MAX_WORDS - 1)) begin
              state_n    = S_FLUSH;
              err_n      = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              to_check_n = 1'b0;
`endif
            end
          end else begin
            assy_n     = merged_c;
            byte_idx_n = byte_idx + 2'd1;
          end
        end
      end
      S_FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_n = to_check ? S_CHECK : S_DONE;
`else
        state_n = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer_c) begin
          if (byte_idx == 2'd3) begin
            state_n    = S_DONE;
            err_n      = (merged_c != sum);
            byte_idx_n = 2'd0;
            assy_n     = '0;
          end else begin
            assy_n     = merged_c;
            byte_idx_n = byte_idx + 2'd1;
          end
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_n = (state_n == S_LOAD) || (state_n == S_CHECK);
`else
    ready_n = (state_n == S_LOAD);
`endif
    busy_n = ready_n || (state_n == S_FLUSH);
    done_n = (state_n == S_DONE);
  end

  // State and registered outputs; reset wins over start and transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_idx <= 2'd0;
      assy     <= '0;
      ready    <= 1'b0;
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      words    <= '0;
      err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= '0;
      to_check <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      byte_idx <= byte_idx_n;
      assy     <= assy_n;
      ready    <= ready_n;
      we       <= we_n;
      wa       <= wa_n;
      wd       <= wd_n;
      busy     <= busy_n;
      done     <= done_n;
      words    <= words_n;
      err      <= err_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= sum_n;
      to_check <= to_check_n;
`endif
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte streams checked against a word-level model.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic        busy, done, err;
  logic [6:0]  words;

  imem_loader_if strm ();

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .strm(strm),
    .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done),
    .words(words), .err(err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  stim_q[$];
  logic [37:0] wlog[$];
  logic [31:0] exp_w[$];
  int          sent;

  // Record every memory write as {wa, wd}.
  always @(negedge clk) if (we) wlog.push_back({wa, wd});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: chop accepted bytes into little-endian words until s_last or 64 words.
  function automatic void model(input int last_idx, output int n_acc, output bit e_err);
    logic [31:0] w;
    int k;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] s, c;
`endif
    w = '0; k = 0; n_acc = 0; e_err = 1'b0; exp_w.delete();
    for (int b = 0; b < stim_q.size(); b++) begin
      w = w | (32'(stim_q[b]) << (8 * k));
      k++;
      if (k == 4 || b == last_idx) begin
        exp_w.push_back(w);
        w = '0; k = 0;
        if (b == last_idx) begin
          n_acc = b + 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          s = '0;
          foreach (exp_w[j]) s = s + exp_w[j];
          c = {stim_q[b+4], stim_q[b+3], stim_q[b+2], stim_q[b+1]};
          e_err = (c != s);
          n_acc = b + 5;
`endif
          return;
        end
        if (exp_w.size() == 64) begin
          n_acc = b + 1;
          e_err = 1'b1;
          return;
        end
      end
    end
    n_acc = stim_q.size();
  endfunction

`ifdef IMEM_LOADER_CHECKSUM_EN
  function automatic logic [31:0] stream_sum(input int last_idx);
    logic [31:0] s, w;
    int k;
    s = '0; w = '0; k = 0;
    for (int b = 0; b <= last_idx; b++) begin
      w = w | (32'(stim_q[b]) << (8 * k));
      k++;
      if (k == 4 || b == last_idx) begin s = s + w; w = '0; k = 0; end
    end
    return s;
  endfunction
`endif

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    strm.s_valid = 1'b0; strm.s_data = 8'h00; strm.s_last = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic begin_session();
    wlog.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Offer stim_q bytes in order; gap_mode 0=every cycle, 1=random, 2=toggle.
  task automatic drive_stream(input int last_idx, input int gap_mode, input bit poke);
    int i, cyc;
    bit go, offer, tog;
    i = 0; cyc = 0; go = 1'b0; tog = 1'b1;
    while (cyc < 4000) begin
      if (done || i >= stim_q.size()) break;
      offer = (gap_mode == 0) ? 1'b1 : (gap_mode == 2) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      strm.s_valid = offer;
      strm.s_data  = stim_q[i];
      strm.s_last  = (i == last_idx);
      start = poke && busy && ($urandom_range(0, 2) == 0);
      go = offer && strm.s_ready;
      @(negedge clk);
      cyc++;
      if (go) i++;
    end
    strm.s_valid = 1'b0; strm.s_last = 1'b0; start = 1'b0;
    sent = i;
    n_tests++;
    if (cyc >= 4000) begin
      n_fail++;
      $display("FAIL stream_budget: only %0d of %0d bytes consumed", i, stim_q.size());
    end
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!done && c < 200) begin @(negedge clk); c++; end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s done_wait: done=%0b after %0d cycles, required 1", name, done, c);
    end
  endtask

  task automatic check_session(input string name, input int last_idx);
    int  n_acc;
    bit  e_err, bad;
    model(last_idx, n_acc, e_err);
    n_tests++;
    if (wlog.size() !== exp_w.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required %0d", name, wlog.size(), exp_w.size());
    end
    bad = 1'b0;
    for (int j = 0; j < exp_w.size() && j < wlog.size(); j++) begin
      if (!bad && wlog[j] !== {6'(j), exp_w[j]}) begin
        bad = 1'b1;
        $display("FAIL %s write_%0d: got wa=%0d wd=%h required wa=%0d wd=%h",
                 name, j, wlog[j][37:32], wlog[j][31:0], j, exp_w[j]);
      end
    end
    n_tests++;
    if (bad) n_fail++;
    n_tests++;
    if (words !== 7'(exp_w.size())) begin
      n_fail++;
      $display("FAIL %s words: got %0d required %0d", name, words, exp_w.size());
    end
    n_tests++;
    if (err !== e_err) begin
      n_fail++;
      $display("FAIL %s err: got %0b required %0b", name, err, e_err);
    end
    n_tests++;
    if (sent !== n_acc) begin
      n_fail++;
      $display("FAIL %s accepted: got %0d bytes required %0d", name, sent, n_acc);
    end
    n_tests++;
    if ({strm.s_ready, busy, done} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s done_flags: got ready/busy/done=%b required 001", name,
               {strm.s_ready, busy, done});
    end
  endtask

  task automatic run_session(input string name, input int last_idx, input int gap_mode,
                             input bit poke, input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] s;
    if (last_idx >= 0) begin
      s = stream_sum(last_idx);
      if (!good) s = s + 32'd1 + 32'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) stim_q.push_back(s[8*k +: 8]);
    end
`endif
    begin_session();
    drive_stream(last_idx, gap_mode, poke);
    wait_done(name);
    check_session(name, last_idx);
  endtask

  task automatic random_bytes(input int n);
    stim_q.delete();
    for (int k = 0; k < n; k++) stim_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({strm.s_ready, we, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got ready/we/busy/done/err=%b required 00000",
               {strm.s_ready, we, busy, done, err});
    end
    n_tests++;
    if (wa !== 6'd0) begin n_fail++; $display("FAIL reset_wa: got %0d required 0", wa); end
    n_tests++;
    if (wd !== 32'd0) begin n_fail++; $display("FAIL reset_wd: got %h required 0", wd); end
    n_tests++;
    if (words !== 7'd0) begin n_fail++; $display("FAIL reset_words: got %0d required 0", words); end
  endtask

  task automatic test_single_word();
    logic [31:0] v;
    v = 32'h2000_0013;
    begin_session();
    for (int k = 0; k < 4; k++) begin
      strm.s_valid = 1'b1; strm.s_data = v[8*k +: 8]; strm.s_last = (k == 3);
      @(negedge clk);
    end
    strm.s_valid = 1'b0; strm.s_last = 1'b0;
    n_tests++;
    if ({we, wa, wd} !== {1'b1, 6'd0, 32'h2000_0013}) begin
      n_fail++;
      $display("FAIL single_write: got we=%0b wa=%0d wd=%h required we=1 wa=0 wd=20000013", we, wa, wd);
    end
    n_tests++;
    if (words !== 7'd1 || strm.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_we_cycle: got words=%0d ready=%0b required words=1 ready=0", words, strm.s_ready);
    end
    @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    n_tests++;
    if ({we, busy, strm.s_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL single_check_entry: got we/busy/ready=%b required 011", {we, busy, strm.s_ready});
    end
    for (int k = 0; k < 4; k++) begin
      strm.s_valid = 1'b1; strm.s_data = v[8*k +: 8];
      @(negedge clk);
    end
    strm.s_valid = 1'b0;
`endif
    n_tests++;
    if ({we, done, err, words} !== {3'b010, 7'd1}) begin
      n_fail++;
      $display("FAIL single_done: got we=%0b done=%0b err=%0b words=%0d required 0 1 0 1", we, done, err, words);
    end
  endtask

  task automatic test_partial();
    random_bytes(8);
    stim_q.push_back(8'hAB);
    run_session("partial", 8, 0, 1'b0, 1'b1);
    n_tests++;
    if (wlog.size() != 3 || wlog[2] !== {6'd2, 32'h0000_00AB} || words !== 7'd3) begin
      n_fail++;
      $display("FAIL partial_tail: got %0d writes, words=%0d, required 3 writes with last wa=2 wd=000000ab",
               wlog.size(), words);
    end
  endtask

  task automatic test_overflow();
    bit bad;
    random_bytes(260);
    run_session("overflow", -1, 0, 1'b0, 1'b1);
    strm.s_valid = 1'b1; bad = 1'b0;
    repeat (5) begin @(negedge clk); if (strm.s_ready) bad = 1'b1; end
    strm.s_valid = 1'b0;
    n_tests++;
    if (bad || wlog.size() != 64) begin
      n_fail++;
      $display("FAIL overflow_closed: got ready_seen=%0b writes=%0d required 0 and 64", bad, wlog.size());
    end
    random_bytes(256);
    run_session("last_on_64th", 255, 0, 1'b0, 1'b1);
    n_tests++;
    if (err !== 1'b0 || words !== 7'd64) begin
      n_fail++;
      $display("FAIL last_on_64th_ok: got err=%0b words=%0d required 0 and 64", err, words);
    end
  endtask

  task automatic test_reset_mid();
    random_bytes(6);
    begin_session();
    drive_stream(-1, 0, 1'b0);
    reset = 1'b1; start = 1'b1; strm.s_valid = 1'b1; strm.s_data = 8'h5A;
    @(negedge clk);
    n_tests++;
    if ({strm.s_ready, we, busy, done, err, wa, wd, words} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got ready=%0b we=%0b busy=%0b done=%0b err=%0b wa=%0d wd=%h words=%0d required all 0",
               strm.s_ready, we, busy, done, err, wa, wd, words);
    end
    n_tests++;
    if (wlog.size() != 1) begin
      n_fail++;
      $display("FAIL reset_mid_writes: got %0d writes required 1", wlog.size());
    end
    reset = 1'b0; start = 1'b0; strm.s_valid = 1'b0;
    random_bytes(10);
    run_session("after_reset", 9, 0, 1'b0, 1'b1);
  endtask

  task automatic test_gappy();
    logic [37:0] ref_log[$];
    int n;
    n = $urandom_range(5, 40);
    random_bytes(n);
    run_session("gapfree", n - 1, 0, 1'b0, 1'b1);
    ref_log = wlog;
    run_session("toggled", n - 1, 2, 1'b1, 1'b1);
    n_tests++;
    if (wlog != ref_log) begin
      n_fail++;
      $display("FAIL toggled_vs_gapfree: got %0d writes required identical %0d", wlog.size(), ref_log.size());
    end
  endtask

  task automatic test_random();
    int last;
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        random_bytes(256 + $urandom_range(0, 8));
        last = -1;
      end else begin
        last = $urandom_range(0, 255);
        random_bytes(last + 1);
      end
      run_session("random", last, $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00};
    begin_session(); drive_stream(7, 0, 1'b0); wait_done("chk_good"); check_session("chk_good", 7);
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL chk_good_err: got %0b required 0", err); end
    stim_q[8] = 8'h04;
    begin_session(); drive_stream(7, 0, 1'b0); wait_done("chk_bad"); check_session("chk_bad", 7);
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL chk_bad_err: got %0b required 1", err); end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_single_word();
    test_partial();
    test_overflow();
    test_reset_mid();
    test_gappy();
    test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
